execute_cycle: RTL

Execute stage of the RISC_YAVA SIMD pipeline. It sits directly downstream of the decode stage and consumes its registered control and 256-bit operand outputs. It performs lane-wise SIMD ALU operations, including a multi-cycle lane multiply that stalls the decode stage. It also resolves branches and registers results into the memory-stage pipeline register.

---
 rtl/simd_pkg.sv | 20 ++
 rtl/execute_cycle_if.sv | 38 +++
 rtl/simd_alu.sv | 39 +++
 rtl/execute_cycle.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the RISC_YAVA SIMD execute stage.
//   - ALU operation codes (ALUControlE encoding)
//   - default SIMD lane width
//   - execute-stage FSM state type
package simd_pkg;

    localparam int SIMD_LANE_W = 16;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_MUL   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    typedef enum logic {IDLE, MUL} exState_t;

endpackage

// File: rtl/execute_cycle_if.sv
// Decode->execute->memory boundary bundle.
//   E-stage inputs : RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE,
//                    ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE
//   E-stage outputs: StallE, PCSrcE, PCTargetE (combinational)
//   M-stage outputs: RegWriteM, MemWriteM, ResultSrcM, RDM, ALUResultM,
//                    WriteDataM, PCPlus4M (registered)
// master = decode side (drives E inputs), slave = execute stage.
interface execute_cycle_if #(parameter int DATA_W = 256);
    localparam int PC_W = 256;

    logic              RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE;
    logic [2:0]        ALUControlE;
    logic [DATA_W-1:0] RD1E, RD2E, ImmExtE;
    logic [PC_W-1:0]   PCE, PCPlus4E;
    logic [4:0]        RDE;

    logic              StallE, PCSrcE;
    logic [PC_W-1:0]   PCTargetE;

    logic              RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]        RDM;
    logic [DATA_W-1:0] ALUResultM, WriteDataM;
    logic [PC_W-1:0]   PCPlus4M;

    modport master (
        output RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE,
        input  StallE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               RDM, ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE,
        output StallE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               RDM, ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/simd_alu.sv
// Combinational lane-wise SIMD ALU (all codes except multiply).
//   aluControl : operation select (simd_pkg ALU_* codes)
//   srcA, srcB : DATA_W operands, split into LANE_W lanes
//   result     : per-lane result, no carries between lanes
// The multiply code yields zero here; the multi-cycle multiplier lives
// in execute_cycle.
module simd_alu import simd_pkg::*; #(
    parameter int DATA_W = 256,
    parameter int LANE_W = SIMD_LANE_W
) (
    input  logic [2:0]        aluControl,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    output logic [DATA_W-1:0] result
);
    localparam int LANES = DATA_W / LANE_W;

    for (genvar i = 0; i < LANES; i++) begin : gLane
        logic [LANE_W-1:0] a, b, r;
        assign a = srcA[i*LANE_W +: LANE_W];
        assign b = srcB[i*LANE_W +: LANE_W];

        always_comb begin
            r = '0;
            case (aluControl)
                ALU_ADD:   r = a + b;
                ALU_SUB:   r = a - b;
                ALU_AND:   r = a & b;
                ALU_OR:    r = a | b;
                ALU_XOR:   r = a ^ b;
                ALU_SLT:   r = ($signed(a) < $signed(b)) ? LANE_W'(1) : '0;
                ALU_PASSB: r = b;
                default:   r = '0;
            endcase
        end

        assign result[i*LANE_W +: LANE_W] = r;
    end
endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the RISC_YAVA SIMD pipeline.
//   clk : pipeline clock, state updates on the falling edge
//   rst : asynchronous active-high reset
//   bus : execute_cycle_if.slave (E-stage inputs, StallE/PCSrcE/PCTargetE,
//         registered M-stage outputs)
// Single-cycle lane ALU ops go straight into the M register. A lane
// multiply is latched into holding registers and computed MUL_LPC lanes
// per edge; decode is stalled until the final slice edge, on which the
// full product is written to M and decode advances.
module execute_cycle import simd_pkg::*; #(
    parameter int DATA_W  = 256,
    parameter int LANE_W  = SIMD_LANE_W,
    parameter int MUL_LPC = 4
) (
    input  logic            clk,
    input  logic            rst,
    execute_cycle_if.slave  bus
);
    localparam int PC_W  = 256;
    localparam int LANES = DATA_W / LANE_W;
    localparam int N     = LANES / MUL_LPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    exState_t          state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] srcB, aluResult;
    logic [DATA_W-1:0] aHold, bHold, rd2Hold, acc, accNext;
    logic [PC_W-1:0]   pc4Hold;
    logic [4:0]        rdHold;
    logic              regWriteHold, memWriteHold, resultSrcHold;
    logic              isMul, zero, lastSlice, stall, pcSrc;
    logic [IDX_W-1:0]  base;

    logic              regWriteM, memWriteM, resultSrcM;
    logic [4:0]        rdM;
    logic [DATA_W-1:0] aluResultM, writeDataM;
    logic [PC_W-1:0]   pcPlus4M;

    assign srcB = bus.ALUSrcE ? bus.ImmExtE : bus.RD2E;

    simd_alu #(.DATA_W(DATA_W), .LANE_W(LANE_W)) uAlu (
        .aluControl(bus.ALUControlE),
        .srcA      (bus.RD1E),
        .srcB      (srcB),
        .result    (aluResult)
    );

    assign isMul     = (bus.ALUControlE == ALU_MUL);
    assign zero      = (aluResult == '0);
    assign lastSlice = (cnt == LAST);

    // Current slice of lanes merged into the accumulator; the product is
    // computed at LANE_W width so only its low bits are kept.
    always_comb begin
        accNext = acc;
        base    = '0;
        for (int j = 0; j < MUL_LPC; j++) begin
            base = IDX_W'((int'(cnt) * MUL_LPC + j) * LANE_W);
            accNext[base +: LANE_W] = aHold[base +: LANE_W] * bHold[base +: LANE_W];
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        pcSrc     = 1'b0;
        case (state)
            IDLE: begin
                stall = isMul;
                pcSrc = bus.BranchE & zero;
                if (isMul) nextState = MUL;
            end
            MUL: begin
                // Release decode on the final slice so the mul is not re-accepted.
                stall = !lastSlice;
                if (lastSlice) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            acc           <= '0;
            aHold         <= '0;
            bHold         <= '0;
            rd2Hold       <= '0;
            pc4Hold       <= '0;
            rdHold        <= '0;
            regWriteHold  <= 1'b0;
            memWriteHold  <= 1'b0;
            resultSrcHold <= 1'b0;
            regWriteM     <= 1'b0;
            memWriteM     <= 1'b0;
            resultSrcM    <= 1'b0;
            rdM           <= '0;
            aluResultM    <= '0;
            writeDataM    <= '0;
            pcPlus4M      <= '0;
        end else begin
            // Bubble by default; overridden when a result retires.
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            resultSrcM <= 1'b0;
            rdM        <= '0;
            aluResultM <= '0;
            writeDataM <= '0;
            pcPlus4M   <= '0;
            if (state == IDLE) begin
                if (isMul) begin
                    aHold         <= bus.RD1E;
                    bHold         <= srcB;
                    rd2Hold       <= bus.RD2E;
                    pc4Hold       <= bus.PCPlus4E;
                    rdHold        <= bus.RDE;
                    regWriteHold  <= bus.RegWriteE;
                    memWriteHold  <= bus.MemWriteE;
                    resultSrcHold <= bus.ResultSrcE;
                    acc           <= '0;
                    cnt           <= '0;
                end else begin
                    regWriteM  <= bus.RegWriteE;
                    memWriteM  <= bus.MemWriteE;
                    resultSrcM <= bus.ResultSrcE;
                    rdM        <= bus.RDE;
                    aluResultM <= aluResult;
                    writeDataM <= bus.RD2E;
                    pcPlus4M   <= bus.PCPlus4E;
                end
            end else begin
                acc <= accNext;
                if (lastSlice) begin
                    cnt        <= '0;
                    regWriteM  <= regWriteHold;
                    memWriteM  <= memWriteHold;
                    resultSrcM <= resultSrcHold;
                    rdM        <= rdHold;
                    aluResultM <= accNext;
                    writeDataM <= rd2Hold;
                    pcPlus4M   <= pc4Hold;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.StallE     = stall;
    assign bus.PCSrcE     = pcSrc;
    assign bus.PCTargetE  = bus.PCE + PC_W'(bus.ImmExtE);
    assign bus.RegWriteM  = regWriteM;
    assign bus.MemWriteM  = memWriteM;
    assign bus.ResultSrcM = resultSrcM;
    assign bus.RDM        = rdM;
    assign bus.ALUResultM = aluResultM;
    assign bus.WriteDataM = writeDataM;
    assign bus.PCPlus4M   = pcPlus4M;
endmodule
